ring_cpt_n: RTL and testbench



---
 rtl/ring_cpt_n.sv | 97 +++++++++
 tb/tb_ring_cpt_n.sv | 112 +++++++++++
 2 files changed

// File: rtl/ring_cpt_n.sv
// Self-correcting ring/Johnson shift counter with up/down, parallel load,
// a wrap pulse and one-edge recovery from illegal states.
module ring_cpt_n #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cpt,
  output logic [IDXW-1:0]  idx,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TOP = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] cpt_q, cpt_d;
  logic             wrap_q, wrap_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] stepVal;
  logic             legal;
  logic             atEnd;

  // Johnson states have at most one boundary between adjacent differing bits
  assign legal = mode ? $onehot0(cpt_q[WIDTH-2:0] ^ cpt_q[WIDTH-1:1])
                      : $onehot(cpt_q);
  assign home  = mode ? '0 : ONE;
  assign atEnd = dir ? (cpt_q == ONE) : (cpt_q == TOP);

  always_comb begin
    stepVal = cpt_q;
    case ({mode, dir})
      2'b00: stepVal = {cpt_q[WIDTH-2:0], cpt_q[WIDTH-1]};
      2'b01: stepVal = {cpt_q[0], cpt_q[WIDTH-1:1]};
      2'b10: stepVal = {cpt_q[WIDTH-2:0], ~cpt_q[WIDTH-1]};
      2'b11: stepVal = {~cpt_q[0], cpt_q[WIDTH-1:1]};
      default: stepVal = cpt_q;
    endcase
  end

  // Load beats correction so that an illegal value can be observed for a cycle
  always_comb begin
    cpt_d     = cpt_q;
    wrap_d    = 1'b0;
    illegal_d = 1'b0;
    if (load) begin
      cpt_d = load_val;
    end else if (!legal) begin
      cpt_d     = home;
      illegal_d = 1'b1;
    end else if (activate) begin
      cpt_d  = stepVal;
      wrap_d = atEnd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpt_q     <= home;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      cpt_q     <= cpt_d;
      wrap_q    <= wrap_d;
      illegal_q <= illegal_d;
    end
  end

  logic [IDXW-1:0] ringIdx;
  int              popCnt;
  int              johnIdx;

  // Johnson index: filling phase counts ones, draining phase counts down from 2W
  always_comb begin
    ringIdx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cpt_q[i]) ringIdx = IDXW'(i);
    end
    popCnt  = $countones(cpt_q);
    johnIdx = cpt_q[0] ? popCnt : (2*WIDTH - popCnt) % (2*WIDTH);
    if (!legal)     idx = '0;
    else if (mode)  idx = IDXW'(johnIdx);
    else            idx = ringIdx;
  end

  assign cpt     = cpt_q;
  assign wrap    = wrap_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_ring_cpt_n.sv
// Directed self-checking bench for ring_cpt_n at WIDTH = 4.
module tb_ring_cpt_n;

  logic       clk = 1'b0;
  logic       reset, activate, mode, dir, load;
  logic [3:0] load_val;
  logic [3:0] cpt;
  logic [2:0] idx;
  logic       wrap, illegal;
  int         total = 0;
  int         bad = 0;

  ring_cpt_n #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .activate(activate), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .cpt(cpt), .idx(idx), .wrap(wrap),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after an edge; outputs are checked there too
  task automatic applyStimulus(input logic r, input logic a, input logic m,
                               input logic d, input logic l, input logic [3:0] lv);
    reset = r; activate = a; mode = m; dir = d; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] eCpt,
                             input logic [2:0] eIdx, input logic eWrap,
                             input logic eIll);
    total++;
    assert (cpt === eCpt) else begin
      bad++; $error("[TB] FAIL %s cpt got=%b exp=%b", tag, cpt, eCpt);
    end
    total++;
    assert (idx === eIdx) else begin
      bad++; $error("[TB] FAIL %s idx got=%0d exp=%0d", tag, idx, eIdx);
    end
    total++;
    assert (wrap === eWrap) else begin
      bad++; $error("[TB] FAIL %s wrap got=%b exp=%b", tag, wrap, eWrap);
    end
    total++;
    assert (illegal === eIll) else begin
      bad++; $error("[TB] FAIL %s illegal got=%b exp=%b", tag, illegal, eIll);
    end
  endtask

  initial begin
    reset = 1'b0; activate = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0;
    load_val = 4'b0000;

    // ring reset and five up steps
    applyStimulus(1, 0, 0, 0, 0, 4'b0000); checkOutput("ringReset", 4'b0001, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'b0000); checkOutput("ringUp1", 4'b0010, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'b0000); checkOutput("ringUp2", 4'b0100, 2, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'b0000); checkOutput("ringUp3", 4'b1000, 3, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'b0000); checkOutput("ringWrap", 4'b0001, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'b0000); checkOutput("ringUp5", 4'b0010, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'b0000); checkOutput("ringUp6", 4'b0100, 2, 0, 0);

    // hold
    applyStimulus(0, 0, 0, 0, 0, 4'b0000); checkOutput("hold1", 4'b0100, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4'b0000); checkOutput("hold2", 4'b0100, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4'b0000); checkOutput("hold3", 4'b0100, 2, 0, 0);

    // illegal load in ring mode
    applyStimulus(0, 0, 0, 0, 1, 4'b0110); checkOutput("illLoad", 4'b0110, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4'b0000); checkOutput("illFix", 4'b0001, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 4'b0000); checkOutput("illClear", 4'b0001, 0, 0, 0);

    // Johnson reset, full up cycle, then two down steps
    applyStimulus(1, 0, 1, 0, 0, 4'b0000); checkOutput("johnReset", 4'b0000, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000); checkOutput("johnUp1", 4'b0001, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000); checkOutput("johnUp2", 4'b0011, 2, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000); checkOutput("johnUp3", 4'b0111, 3, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000); checkOutput("johnUp4", 4'b1111, 4, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000); checkOutput("johnUp5", 4'b1110, 5, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000); checkOutput("johnUp6", 4'b1100, 6, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000); checkOutput("johnUp7", 4'b1000, 7, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000); checkOutput("johnWrap", 4'b0000, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0, 4'b0000); checkOutput("johnDn1", 4'b1000, 7, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 4'b0000); checkOutput("johnDn2", 4'b1100, 6, 0, 0);

    // mode switch out of a state that is illegal for ring, then back
    applyStimulus(0, 0, 1, 0, 1, 4'b0011); checkOutput("johnLoad", 4'b0011, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4'b0000); checkOutput("toRing", 4'b0001, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 4'b0000); checkOutput("toJohn", 4'b0001, 1, 0, 0);

    // Johnson down wrap from 0001 lands on home
    applyStimulus(0, 1, 1, 1, 0, 4'b0000); checkOutput("johnDnWrap", 4'b0000, 0, 1, 0);

    // illegal Johnson pattern corrected even while activate is high
    applyStimulus(0, 0, 1, 0, 1, 4'b0101); checkOutput("johnIllLoad", 4'b0101, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'b0000); checkOutput("johnIllFix", 4'b0000, 0, 0, 1);

    // ring down: 0000 is illegal for ring, then down wrap lands on 1000
    applyStimulus(0, 1, 0, 1, 0, 4'b0000); checkOutput("ringFix", 4'b0001, 0, 0, 1);
    applyStimulus(0, 1, 0, 1, 0, 4'b0000); checkOutput("ringDnWrap", 4'b1000, 3, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 4'b0000); checkOutput("ringDn", 4'b0100, 2, 0, 0);

    // priority: reset over load over activate
    applyStimulus(1, 1, 0, 0, 1, 4'b1000); checkOutput("prioReset", 4'b0001, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 4'b1000); checkOutput("prioLoad", 4'b1000, 3, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'b0000); checkOutput("prioStep", 4'b0001, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
